// File: rtl/fp_add_drain_pkg.sv
// Shared types, field widths and result classification for the fp adder drain stage.
package fp_add_drain_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned FLG_W  = 4;

    localparam int unsigned FLG_NAN    = 3;
    localparam int unsigned FLG_INF    = 2;
    localparam int unsigned FLG_ZERO   = 1;
    localparam int unsigned FLG_DENORM = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    typedef logic [FLG_W-1:0] fp_flags_t;

    typedef struct packed {
        fp_word_t  word;
        fp_flags_t flags;
    } drain_entry_t;

    // {nan, inf, zero, denorm} of a single-precision word
    function automatic fp_flags_t classify(input fp_word_t w);
        fp_flags_t f;
        logic      exp_max;
        logic      exp_zero;
        logic      man_zero;
        exp_max  = &w.exp;
        exp_zero = ~|w.exp;
        man_zero = ~|w.man;
        f             = '0;
        f[FLG_NAN]    = exp_max & ~man_zero;
        f[FLG_INF]    = exp_max & man_zero;
        f[FLG_ZERO]   = exp_zero & man_zero;
        f[FLG_DENORM] = exp_zero & ~man_zero;
        return f;
    endfunction

endpackage

// File: rtl/fp_add_drain_fifo.sv
// DEPTH x W synchronous FIFO with occupancy count; head word reads as zero when empty.
module fp_add_drain_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head_c,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; empty reads are masked below
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        head_c = '0;
        if (count != '0) begin
            head_c = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fp_add_drain.sv
// Drain stage behind the pipelined fp adder: tracks live pipe slots, buffers results, stalls the adder.
// Optional flag storage enabled by defining FP_ADD_DRAIN_FLAGS_EN.
module fp_add_drain
    import fp_add_drain_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic               aclk,
    input  logic               arst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  x,
    output logic               astall,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic [FLG_W-1:0]   out_flags,
    output logic [AW:0]        count
);

    logic [LATENCY-1:0] vpipe;
    logic               issue;
    logic               tail;
    logic               pop;
    logic               push;
    logic               full;

    assign issue     = in_valid & in_ready;
    assign tail      = vpipe[LATENCY-1];
    assign pop       = out_valid & out_ready;
    assign full      = (count == (AW+1)'(DEPTH));
    assign astall    = tail & full & ~pop;
    assign in_ready  = ~astall;
    assign push      = tail & ~astall;
    assign out_valid = (count != '0);

    // Valid bits mirror the adder pipe, frozen together with it
    generate
        if (LATENCY == 1) begin : g_vpipe_one
            always_ff @(posedge aclk or negedge arst_n) begin
                if (!arst_n) begin
                    vpipe <= '0;
                end else if (!astall) begin
                    vpipe <= issue;
                end
            end
        end else begin : g_vpipe_many
            always_ff @(posedge aclk or negedge arst_n) begin
                if (!arst_n) begin
                    vpipe <= '0;
                end else if (!astall) begin
                    vpipe <= {vpipe[LATENCY-2:0], issue};
                end
            end
        end
    endgenerate

`ifdef FP_ADD_DRAIN_FLAGS_EN
    localparam int unsigned ENTRY_W = $bits(drain_entry_t);

    drain_entry_t wr_entry;
    drain_entry_t rd_entry;
    logic [ENTRY_W-1:0] head;

    // Classification happens on the way in so the head is just a register read
    always_comb begin
        wr_entry       = '0;
        wr_entry.word  = fp_word_t'(x);
        wr_entry.flags = classify(fp_word_t'(x));
    end

    fp_add_drain_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .AW    (AW)
    ) u_fifo (
        .clk    (aclk),
        .rst_n  (arst_n),
        .push   (push),
        .pop    (pop),
        .din    (wr_entry),
        .head_c (head),
        .count  (count)
    );

    assign rd_entry  = head;
    assign out_data  = rd_entry.word;
    assign out_flags = rd_entry.flags;
`else
    fp_add_drain_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W),
        .AW    (AW)
    ) u_fifo (
        .clk    (aclk),
        .rst_n  (arst_n),
        .push   (push),
        .pop    (pop),
        .din    (x),
        .head_c (out_data),
        .count  (count)
    );

    assign out_flags = '0;
`endif

endmodule

// File: doc/fp_add_drain.md
Name: fp_add_drain

Overview:
Downstream drain stage for the pipelined single-precision adder (E8/M23, result registered LATENCY cycles behind its operands, pipe frozen by astall).
- Tracks which pipe slots hold real operations.
- Captures the adder's 32-bit result word into a small result FIFO.
- Presents results on a valid/ready interface and back-pressures the adder via astall when the FIFO cannot absorb.

Parameters:
LATENCY, 2, adder pipe depth in enabled clock cycles (1..8).
DEPTH, 4, result FIFO entries (power of two, 2..16).
AW, $clog2(DEPTH), FIFO pointer width (derived; do not override).

Ports:
aclk  input  1  clock, rising edge.
arst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands presented to adder this cycle are real.
in_ready  output  1  issue accepted when in_valid & in_ready.
x  input  32  adder result word {sign, exp[7:0], man[22:0]}.
astall  output  1  freezes adder pipe (drives adder astall).
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer accepts head.
out_data  output  32  FIFO head result word.
out_flags  output  4  {nan, inf, zero, denorm} of out_data (see Optional Feature).
count  output  AW+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - vpipe = 0, FIFO pointers and count = 0.
  - out_valid = 0, astall = 0, in_ready = 1, out_data = 0, out_flags = 0.
- Valid pipe vpipe[LATENCY-1:0]:
  - When ~astall: vpipe shifts, vpipe[0] <= in_valid & in_ready.
  - When astall: vpipe holds, matching the frozen adder pipe.
- tail = vpipe[LATENCY-1]. Sampled x is meaningful only when tail = 1.
- pop = out_valid & out_ready.
- push = tail & ~astall. x is written at the write pointer.
- astall = tail & (count == DEPTH) & ~pop. Combinational, no other terms.
- in_ready = ~astall.
- Simultaneous push and pop at full: allowed, count unchanged, no stall.
- Simultaneous push and pop at empty: not possible, because out_valid = 0 when empty.
- count updates as count + push - pop. Never exceeds DEPTH, never underflows.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0).
- out_data / out_flags are driven combinationally from the head entry; they hold stable while out_valid & ~out_ready.
- Latency: an issue accepted at cycle t with no stalls yields out_valid at t+LATENCY+1 (one FIFO write cycle).
- Ordering: results leave strictly in issue order; no drops, no duplicates.
- Reset mid-operation: all in-flight and buffered results are discarded.

Optional Feature:
Macro FP_ADD_DRAIN_FLAGS_EN.
- Defined:
  - On push, classify x and store 4 flag bits alongside the result word in the FIFO.
  - nan = exp==FF & man!=0.
  - inf = exp==FF & man==0.
  - zero = exp==0 & man==0.
  - denorm = exp==0 & man!=0.
- Undefined: no flag storage; out_flags is tied to 0.

Decomposition:
- Package fp_add_drain_pkg holds:
  - Field widths EXP_W=8, MAN_W=23, WORD_W=32.
  - Flag bit index constants FLG_NAN=3, FLG_INF=2, FLG_ZERO=1, FLG_DENORM=0.
  - The classify function.
- One sub-module: fp_add_drain_fifo, a DEPTH x width synchronous FIFO with count. The top holds vpipe, stall logic and classification.

Test Plan:
- Single issue, out_ready=1, LATENCY=2, x=0x3F800000 when tail → out_valid 3 cycles after issue, out_data=0x3F800000, astall never 1.
- Stream of 8 issues, out_ready=0, DEPTH=4 → count reaches 4; astall asserts the cycle tail=1 with count 4; in_ready=0; vpipe frozen.
- Then raise out_ready → all 8 results in order, count returns to 0, no loss.
- Full FIFO with tail=1 and out_ready=1 in the same cycle → astall=0, push and pop both occur, count stays 4.
- Bubbles: in_valid pattern 1,0,1,1,0,1 with x driven to garbage on non-tail cycles → exactly 4 results, garbage never enqueued.
- arst_n pulsed low with 3 in flight and 2 buffered → out_valid=0, count=0, astall=0 immediately; the next issue is the first result out.
- With FP_ADD_DRAIN_FLAGS_EN: x=0x7FC00000→flags 1000; 0xFF800000→0100; 0x80000000→0010; 0x00000001→0001; 0x40490FDB→0000.
